// File: rtl/ram_fifo_ctrl.sv
// Show-ahead FIFO controller for a 1rw1r RAM macro: port 0 takes pushes, port 1 prefetches
// the next head into the RAM's registered read output, which doubles as the output slot.
module ram_fifo_ctrl #(
    parameter int DBITS = 64,
    parameter int ABITS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [DBITS-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DBITS-1:0] m_data,
    output logic [ABITS:0]   count,
    output logic [ABITS-1:0] ram_addr0,
    output logic             ram_re0,
    output logic [DBITS-1:0] ram_wr0,
    output logic             ram_we0,
    output logic [ABITS-1:0] ram_addr1,
    output logic             ram_re1,
    input  logic [DBITS-1:0] ram_rd1
);

    localparam logic [ABITS:0] RAM_FULL = (ABITS + 1)'(2 ** ABITS);

    logic [ABITS-1:0] wptr;
    logic [ABITS-1:0] rptr;
    logic [ABITS:0]   ram_cnt;
    logic             push;
    logic             pref;

    // s_ready looks only at RAM occupancy, so it never depends on m_ready.
    assign s_ready = (ram_cnt != RAM_FULL);
    assign push    = s_valid & s_ready;
    assign pref    = (ram_cnt != '0) & (~m_valid | m_ready) & ~flush;

    assign ram_addr0 = wptr;
    assign ram_re0   = 1'b0;
    assign ram_wr0   = s_data;
    // The RAM keeps running through reset, so the write strobe is gated by rst_n directly.
    assign ram_we0   = push & ~flush & rst_n;
    assign ram_addr1 = rptr;
    assign ram_re1   = pref;

    assign m_data = ram_rd1;
    assign count  = ram_cnt + {{ABITS{1'b0}}, m_valid};

    // NOTE: only the control state is reset; the RAM contents are left alone because
    // every entry is rewritten before it is read again, and a macro cannot be cleared anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            m_valid <= 1'b0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            m_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every branch reads the pre-edge state.
            if (push) wptr <= wptr + ABITS'(1);
            if (pref) rptr <= rptr + ABITS'(1);

            if (push && !pref)      ram_cnt <= ram_cnt + (ABITS + 1)'(1);
            else if (!push && pref) ram_cnt <= ram_cnt - (ABITS + 1)'(1);

            if (pref)         m_valid <= 1'b1;
            else if (m_ready) m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with ABITS=2: a behavioural RAM, a queue-based reference model,
// directed scenarios and a long randomized run.
module tb_ram_fifo_ctrl;

    localparam int DB = 64;
    localparam int AB = 2;
    localparam int D  = 2 ** AB;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [DB-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DB-1:0] m_data;
    logic [AB:0]   count;
    logic [AB-1:0] ram_addr0;
    logic          ram_re0;
    logic [DB-1:0] ram_wr0;
    logic          ram_we0;
    logic [AB-1:0] ram_addr1;
    logic          ram_re1;
    logic [DB-1:0] ram_rd1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: every entry held, oldest first; slot says whether the head is presented.
    logic [DB-1:0] q[$];
    bit            slot;

    ram_fifo_ctrl #(.DBITS(DB), .ABITS(AB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .count(count),
        .ram_addr0(ram_addr0), .ram_re0(ram_re0), .ram_wr0(ram_wr0), .ram_we0(ram_we0),
        .ram_addr1(ram_addr1), .ram_re1(ram_re1), .ram_rd1(ram_rd1)
    );

    always #5 clk = ~clk;

    // 1rw1r RAM: registered port-1 read, read on port 0 wins over write.
    logic [DB-1:0] mem [D];
    always @(posedge clk) begin
        if (ram_we0 && !ram_re0) mem[ram_addr0] <= ram_wr0;
        if (ram_re1) ram_rd1 <= mem[ram_addr1];
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs mid-cycle against the model, then advance both.
    task automatic step();
        int inram;
        bit exp_ready, push, pop, pref;
        @(negedge clk);
        inram     = q.size() - int'(slot);
        exp_ready = (inram != D);
        push      = s_valid && exp_ready;
        pop       = slot && m_ready;
        pref      = (inram > 0) && (!slot || m_ready) && !flush;
        check("s_ready", s_ready, exp_ready);
        check("m_valid", m_valid, slot);
        check("count", count, q.size());
        check("ram_we0", ram_we0, push && !flush);
        check("ram_re1", ram_re1, pref);
        check("ram_re0", ram_re0, 0);
        if (slot) check("m_data", m_data, q[0]);
        @(posedge clk);
        if (flush) begin
            q.delete();
            slot = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(s_data);
            if (pref) slot = 1'b1;
            else if (pop) slot = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b1;
        s_data  = 64'hDEAD;
        m_ready = 1'b1;
        slot    = 1'b0;

        // Reset state, with a push request held to show no write escapes.
        #2;
        check("rst_s_ready", s_ready, 1);
        check("rst_we0", ram_we0, 0);
        check("rst_re1", ram_re1, 0);
        check("rst_count", count, 0);
        check("rst_m_valid", m_valid, 0);
        repeat (2) @(posedge clk);
        #1;
        s_valid = 1'b0;
        rst_n   = 1'b1;
        repeat (2) step();

        // Single push into empty: prefetch one cycle later, head visible the cycle after.
        s_valid = 1'b1; s_data = 64'hA1; m_ready = 1'b0;
        step();
        s_valid = 1'b0;
        #1 check("lat_re1", ram_re1, 1);
        step();
        check("lat_m_valid", m_valid, 1);
        check("lat_m_data", m_data, 64'hA1);
        m_ready = 1'b1;
        step();
        check("lat_drained", count, 0);

        // Fill to capacity D+1 with the consumer stalled, then drain in order.
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            s_valid = 1'b1; s_data = 64'(i);
            step();
        end
        s_valid = 1'b0;
        #1;
        check("full_count", count, 5);
        check("full_s_ready", s_ready, 0);
        m_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1;
            check("drain_valid", m_valid, 1);
            check("drain_data", m_data, 64'(i));
            step();
        end
        check("drain_empty", count, 0);

        // Streaming: after start-up, one entry waits in the RAM behind the presented head.
        m_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1; s_data = 64'(i);
            step();
            if (i >= 1) begin
                check("stream_valid", m_valid, 1);
                check("stream_data", m_data, 64'(i - 1));
                check("stream_count", count, 2);
            end
        end
        s_valid = 1'b0;
        repeat (3) step();
        check("stream_empty", count, 0);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            flush   = ($urandom_range(0, 255) == 0);
            s_data  = {$urandom, $urandom};
            step();
        end
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
        repeat (8) step();
        check("rand_empty", count, 0);

        // Flush overrides a simultaneous push and pop.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 64'(16 + i);
            step();
        end
        s_valid = 1'b1; s_data = 64'h77; m_ready = 1'b1; flush = 1'b1;
        #1;
        check("flush_we0", ram_we0, 0);
        check("flush_re1", ram_re1, 0);
        step();
        flush = 1'b0; s_valid = 1'b0;
        #1;
        check("flush_count", count, 0);
        check("flush_m_valid", m_valid, 0);
        s_valid = 1'b1; s_data = 64'h55; m_ready = 1'b0;
        step();
        s_valid = 1'b0;
        repeat (2) step();
        check("post_flush_valid", m_valid, 1);
        check("post_flush_data", m_data, 64'h55);

        // Reset mid-operation drops everything and issues no write.
        s_valid = 1'b1; s_data = 64'h99;
        step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_we0", ram_we0, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_s_ready", s_ready, 1);
        q.delete();
        slot = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        s_valid = 1'b0;
        rst_n   = 1'b1;
        s_valid = 1'b1; s_data = 64'h3C; m_ready = 1'b1;
        step();
        s_valid = 1'b0;
        repeat (3) step();
        check("post_rst_empty", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
